// File: rtl/pit_pkg.sv
// -----------------------------------------------------------------------------
// pit_pkg
// Shared constants and types for the PIT configuration arbiter:
//   - default PIT register offsets (CONTROL at 0x0, DELAY at 0x4)
//   - bit positions inside the 2-bit per-requester control field
//   - AXI response encodings
//   - arbiter FSM state encoding (also exported on the debug port)
// -----------------------------------------------------------------------------
package pit_pkg;

    localparam logic [3:0] PIT_CONTROL_OFFSET = 4'h0;
    localparam logic [3:0] PIT_DELAY_OFFSET   = 4'h4;

    // Control field layout: {irq_en, enable}
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_DLY_ADDR = 3'd2,
        ST_DLY_RESP = 3'd3,
        ST_CTL_ADDR = 3'd4,
        ST_CTL_RESP = 3'd5,
        ST_DONE     = 3'd6
    } arb_state_t;

endpackage

// File: rtl/pit_config_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request found when searching
// upward from i_ptr+1, wrapping around, so the last winner has lowest priority.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [IDX_W]    index of the previous winner
//   o_grant [NUM_REQ]  one-hot grant (all zero when no request)
//   o_idx   [IDX_W]    index of the granted requester
//   o_any   1          at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sel   = '0;
        // Offsets 1..NUM_REQ; offset NUM_REQ revisits the previous winner last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sel = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/pit_config_arbiter.sv
// -----------------------------------------------------------------------------
// pit_config_arbiter
// Shares one PIT between NUM_REQ requesters. A request is granted round-robin,
// then programmed into the PIT over AXI4-Lite as a DELAY write followed by a
// CONTROL write. The requester that last configured the PIT successfully is
// the owner; the PIT interrupt is routed only to it.
// Ports:
//   s_axi_aclk, reset           clock, async active-high reset
//   req_valid/req_delay/req_ctrl per-requester request (held until req_done)
//   req_done, req_err            1-cycle completion pulse and error flag
//   owner, owner_valid           current owner and whether its timer runs
//   irq_out                      registered, routed PIT interrupt
//   m_axi_aw*/w*/b*              AXI4-Lite write master towards the PIT
//   pit_irq                      raw PIT interrupt
//   o_dbg_state                  current FSM state
// Handshake: a transfer on any AXI channel happens on the clock edge where
// valid and ready are both high; a raised valid is held with stable payload
// until that edge and dropped on the following cycle.
// -----------------------------------------------------------------------------
module pit_config_arbiter
    import pit_pkg::*;
#(
    parameter int                    NUM_REQ        = 4,
    parameter int                    ADDR_WIDTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] CONTROL_OFFSET = ADDR_WIDTH'(PIT_CONTROL_OFFSET),
    parameter logic [ADDR_WIDTH-1:0] DELAY_OFFSET   = ADDR_WIDTH'(PIT_DELAY_OFFSET),
    localparam int                   IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                    s_axi_aclk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_delay,
    input  logic [NUM_REQ*2-1:0]    req_ctrl,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic [IDX_W-1:0]        owner,
    output logic                    owner_valid,
    output logic [NUM_REQ-1:0]      irq_out,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    pit_irq,
    output arb_state_t              o_dbg_state
);

    arb_state_t        r_state, w_next;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_delay;
    logic [1:0]        r_ctrl;
    logic              r_err;
    logic              r_aw_done;
    logic              r_w_done;
    logic [IDX_W-1:0]  r_owner;
    logic              r_owner_valid;
    logic [NUM_REQ-1:0] r_irq;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic [31:0]        w_sel_delay;
    logic [1:0]         w_sel_ctrl;
    logic               w_reject;
    logic               w_addr_phase;
    logic               w_resp_phase;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_phase_done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    // One-hot AND-OR mux of the granted requester's payload.
    always_comb begin
        w_sel_delay = '0;
        w_sel_ctrl  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_delay = w_sel_delay | req_delay[32*i +: 32];
                w_sel_ctrl  = w_sel_ctrl  | req_ctrl[2*i +: 2];
            end
        end
    end

    // Enabling the timer with a zero delay is refused without touching the PIT.
    assign w_reject = w_sel_ctrl[CTRL_ENABLE_BIT] && (w_sel_delay == 32'd0);

    assign w_addr_phase = (r_state == ST_DLY_ADDR) || (r_state == ST_CTL_ADDR);
    assign w_resp_phase = (r_state == ST_DLY_RESP) || (r_state == ST_CTL_RESP);

    assign m_axi_awvalid = w_addr_phase && !r_aw_done;
    assign m_axi_wvalid  = w_addr_phase && !r_w_done;
    assign m_axi_bready  = w_resp_phase;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awaddr  = (r_state == ST_CTL_ADDR) ? CONTROL_OFFSET : DELAY_OFFSET;
    assign m_axi_wdata   = (r_state == ST_CTL_ADDR) ? {30'b0, r_ctrl} : r_delay;

    assign w_aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_w_hs  = m_axi_wvalid && m_axi_wready;
    // AW and W complete independently; the phase ends once both have been seen.
    assign w_phase_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    always_ff @(posedge s_axi_aclk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (|req_valid) w_next = ST_ARB;
            ST_ARB: begin
                if (!w_gnt_any)    w_next = ST_IDLE;
                else if (w_reject) w_next = ST_DONE;
                else               w_next = ST_DLY_ADDR;
            end
            ST_DLY_ADDR: if (w_phase_done) w_next = ST_DLY_RESP;
            // A failed DELAY write still proceeds to CONTROL.
            ST_DLY_RESP: if (m_axi_bvalid) w_next = ST_CTL_ADDR;
            ST_CTL_ADDR: if (w_phase_done) w_next = ST_CTL_RESP;
            ST_CTL_RESP: if (m_axi_bvalid) w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge reset) begin
        if (reset) begin
            r_ptr         <= '0;
            r_idx         <= '0;
            r_delay       <= '0;
            r_ctrl        <= '0;
            r_err         <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_owner       <= '0;
            r_owner_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ARB: begin
                    if (w_gnt_any) begin
                        r_idx   <= w_gnt_idx;
                        r_ptr   <= w_gnt_idx;
                        r_delay <= w_sel_delay;
                        r_ctrl  <= w_sel_ctrl;
                        r_err   <= w_reject;
                    end
                end
                ST_DLY_ADDR, ST_CTL_ADDR: begin
                    if (w_phase_done) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                ST_DLY_RESP, ST_CTL_RESP: begin
                    if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) r_err <= 1'b1;
                end
                ST_DONE: begin
                    // A failed configuration leaves the previous owner in place.
                    if (!r_err) begin
                        r_owner       <= r_idx;
                        r_owner_valid <= r_ctrl[CTRL_ENABLE_BIT];
                    end
                end
                default: ;
            endcase
        end
    end

    // Uses the owner registers as they stand, so during reconfiguration the
    // old owner keeps receiving interrupts until the DONE update lands.
    always_ff @(posedge s_axi_aclk or posedge reset) begin
        if (reset) begin
            r_irq <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_irq[i] <= pit_irq && r_owner_valid && (r_owner == IDX_W'(i));
            end
        end
    end

    always_comb begin
        req_done = '0;
        if (r_state == ST_DONE) req_done[r_idx] = 1'b1;
    end

    assign req_err     = (r_state == ST_DONE) && r_err;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;
    assign irq_out     = r_irq;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pit_config_arbiter.sv
module tb_pit_config_arbiter;
    import pit_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam logic [3:0] CTL_OFF = 4'h0;
    localparam logic [3:0] DLY_OFF = 4'h4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_delay;
    logic [N*2-1:0]  req_ctrl;
    logic [N-1:0]    req_done;
    logic            req_err;
    logic [IW-1:0]   owner;
    logic            owner_valid;
    logic [N-1:0]    irq_out;
    logic            m_axi_awvalid, m_axi_awready;
    logic [3:0]      m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_wvalid, m_axi_wready;
    logic [31:0]     m_axi_wdata;
    logic [3:0]      m_axi_wstrb;
    logic            m_axi_bvalid, m_axi_bready;
    logic [1:0]      m_axi_bresp;
    logic            pit_irq;
    arb_state_t      dbg_state;

    pit_config_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(4)) dut (
        .s_axi_aclk    (clk),
        .reset         (rst),
        .req_valid     (req_valid),
        .req_delay     (req_delay),
        .req_ctrl      (req_ctrl),
        .req_done      (req_done),
        .req_err       (req_err),
        .owner         (owner),
        .owner_valid   (owner_valid),
        .irq_out       (irq_out),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (m_axi_bresp),
        .pit_irq       (pit_irq),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic aborted = 1'b0;

    // {err, owner_valid_after, owner_after[1:0], idx[1:0]}
    logic [5:0]  exp_done_q[$];
    // {addr[3:0], data[31:0]}
    logic [35:0] exp_wr_q[$];
    logic [1:0]  resp_q[$];

    // reference model
    int            m_ptr = 0;
    logic [IW-1:0] m_owner = '0;
    logic          m_ov = 1'b0;

    // per-round request table
    logic [31:0] t_delay[N];
    logic [1:0]  t_ctrl[N];
    logic [1:0]  t_bd[N];
    logic [1:0]  t_bc[N];

    // slave behaviour knobs
    logic sl_mode  = 1'b0;
    logic sl_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- AXI-Lite PIT slave + write monitor ----------------
    initial begin : axi_slave
        logic sl_have_aw, sl_have_w, hs_aw, hs_w, hs_b;
        logic prev_aw_pend, prev_w_pend;
        logic [3:0]  sl_aw_addr, prev_aw_addr;
        logic [31:0] sl_w_data, prev_w_data;
        logic [35:0] e;
        int sl_aw_age, sl_b_wait;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        sl_have_aw = 1'b0; sl_have_w = 1'b0;
        prev_aw_pend = 1'b0; prev_w_pend = 1'b0;
        sl_aw_addr = '0; sl_w_data = '0; prev_aw_addr = '0; prev_w_data = '0;
        sl_aw_age = 0; sl_b_wait = 0;
        hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sl_have_aw = 1'b0; sl_have_w = 1'b0;
                prev_aw_pend = 1'b0; prev_w_pend = 1'b0;
                hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0;
            end else begin
                if (prev_aw_pend) check("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr}), 64'({1'b1, prev_aw_addr}));
                if (prev_w_pend)  check("w_hold", 64'({m_axi_wvalid, m_axi_wdata}), 64'({1'b1, prev_w_data}));
                if (m_axi_awvalid) check("awprot", 64'(m_axi_awprot), 64'(0));
                if (m_axi_wvalid)  check("wstrb", 64'(m_axi_wstrb), 64'(4'hF));
                if (sl_have_aw) check("aw_dropped_after_hs", 64'(m_axi_awvalid), 64'(0));
                if (sl_have_w)  check("w_dropped_after_hs", 64'(m_axi_wvalid), 64'(0));
                hs_aw = m_axi_awvalid && m_axi_awready;
                hs_w  = m_axi_wvalid && m_axi_wready;
                hs_b  = m_axi_bvalid && m_axi_bready;
                prev_aw_pend = m_axi_awvalid && !m_axi_awready;
                prev_w_pend  = m_axi_wvalid && !m_axi_wready;
                prev_aw_addr = m_axi_awaddr;
                prev_w_data  = m_axi_wdata;
                if (hs_aw) begin sl_have_aw = 1'b1; sl_aw_addr = m_axi_awaddr; sl_aw_age = 0; end
                if (hs_w)  begin sl_have_w = 1'b1; sl_w_data = m_axi_wdata; end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                sl_have_aw = 1'b0; sl_have_w = 1'b0;
            end else begin
                if (hs_b) m_axi_bvalid = 1'b0;
                if (sl_have_aw) sl_aw_age++;
                if (sl_have_aw && sl_have_w && !m_axi_bvalid) begin
                    if (sl_b_wait > 0) begin
                        sl_b_wait--;
                    end else begin
                        if (exp_wr_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", sl_aw_addr, sl_w_data);
                            m_axi_bresp = 2'b00;
                        end else begin
                            e = exp_wr_q.pop_front();
                            check("wr_addr", 64'(sl_aw_addr), 64'(e[35:32]));
                            check("wr_data", 64'(sl_w_data), 64'(e[31:0]));
                            m_axi_bresp = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                        end
                        m_axi_bvalid = 1'b1;
                        sl_have_aw = 1'b0;
                        sl_have_w  = 1'b0;
                        sl_b_wait  = $urandom_range(0, 2);
                    end
                end
                m_axi_awready = !sl_stall && !sl_have_aw && (sl_mode ? 1'b1 : ($urandom_range(0, 2) != 0));
                m_axi_wready  = !sl_stall && !sl_have_w &&
                                (sl_mode ? (sl_have_aw && sl_aw_age >= 2) : ($urandom_range(0, 2) != 0));
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin : done_monitor
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_done != '0) begin
                    if (exp_done_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done actual=%b required=none", req_done);
                    end else begin
                        e = exp_done_q.pop_front();
                        check("done_vector", 64'(req_done), 64'(4'b0001 << e[1:0]));
                        check("done_err", 64'(req_err), 64'(e[5]));
                        @(negedge clk);
                        if (!rst) begin
                            check("owner_after_done", 64'(owner), 64'(e[3:2]));
                            check("owner_valid_after_done", 64'(owner_valid), 64'(e[4]));
                        end
                    end
                end else begin
                    check("err_without_done", 64'(req_err), 64'(0));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [31:0] d, input logic [1:0] c,
                           input logic [1:0] bd, input logic [1:0] bc);
        t_delay[i] = d; t_ctrl[i] = c; t_bd[i] = bd; t_bc[i] = bc;
    endtask

    // Plans the expected service order for a set of simultaneous requests,
    // then drives them and waits until every requester has been served.
    task automatic run_round(input logic [N-1:0] mask, input logic do_irq);
        logic [N-1:0]  pend;
        logic [IW-1:0] old_owner;
        logic          old_ov, rej, err;
        int            g, budget, cand;
        old_owner = m_owner;
        old_ov    = m_ov;
        pend      = mask;
        while (pend != '0) begin
            // winner: pending index with the smallest cyclic distance past m_ptr
            g = -1;
            for (int k = 1; k <= N; k++) begin
                cand = (m_ptr + k) % N;
                if (g < 0 && pend[cand]) g = cand;
            end
            pend[g] = 1'b0;
            m_ptr   = g;
            rej = t_ctrl[g][0] && (t_delay[g] == 32'd0);
            if (!rej) begin
                exp_wr_q.push_back({DLY_OFF, t_delay[g]});
                exp_wr_q.push_back({CTL_OFF, 30'b0, t_ctrl[g]});
                resp_q.push_back(t_bd[g]);
                resp_q.push_back(t_bc[g]);
            end
            err = rej || (t_bd[g] != 2'b00) || (t_bc[g] != 2'b00);
            if (!err) begin
                m_owner = IW'(g);
                m_ov    = t_ctrl[g][0];
            end
            exp_done_q.push_back({err, m_ov, m_owner, IW'(g)});
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_delay[32*i +: 32] = t_delay[i];
            req_ctrl[2*i +: 2]    = t_ctrl[i];
        end
        req_valid = mask;
        pit_irq   = do_irq;
        @(negedge clk);
        check("irq_to_old_owner", 64'(irq_out),
              64'((do_irq && old_ov) ? (4'b0001 << old_owner) : 4'b0000));
        pit_irq = 1'b0;
        budget  = 0;
        while ((req_valid != '0 || exp_done_q.size() != 0) && budget < 400) begin
            @(negedge clk);
            req_valid = req_valid & ~req_done;
            budget++;
        end
        if (budget >= 400) begin
            n_checks++; n_fail++;
            $display("FAIL round_timeout actual=pending %b required=0000", req_valid);
            aborted = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("irq_idle_low", 64'(irq_out), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_done"}, 64'(req_done), 64'(0));
        check({tag, "_req_err"}, 64'(req_err), 64'(0));
        check({tag, "_owner"}, 64'(owner), 64'(0));
        check({tag, "_owner_valid"}, 64'(owner_valid), 64'(0));
        check({tag, "_irq_out"}, 64'(irq_out), 64'(0));
        check({tag, "_aw_w_valid"}, 64'({m_axi_awvalid, m_axi_wvalid}), 64'(0));
        check({tag, "_bready"}, 64'(m_axi_bready), 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int budget;
        req_valid = '0;
        req_delay = '0;
        req_ctrl  = '0;
        pit_irq   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single request; AW accepted two cycles before W
        sl_mode = 1'b1;
        set_req(0, 32'd100, 2'b11, 2'b00, 2'b00);
        run_round(4'b0001, 1'b0);
        sl_mode = 1'b0;

        // two simultaneous requests: 1 before 3
        if (!aborted) begin
            set_req(1, 32'd20, 2'b11, 2'b00, 2'b00);
            set_req(3, 32'd30, 2'b01, 2'b00, 2'b00);
            run_round(4'b1010, 1'b1);
        end

        // enable with zero delay is refused without bus traffic
        if (!aborted) begin
            set_req(2, 32'd0, 2'b01, 2'b00, 2'b00);
            run_round(4'b0100, 1'b1);
        end

        // requester 2 takes ownership, then fails on CONTROL with SLVERR
        if (!aborted) begin
            set_req(2, 32'd50, 2'b11, 2'b00, 2'b00);
            run_round(4'b0100, 1'b0);
        end
        if (!aborted) begin
            set_req(2, 32'd75, 2'b11, 2'b00, 2'b10);
            run_round(4'b0100, 1'b1);
        end

        // randomized rounds
        for (int r = 0; r < 40 && !aborted; r++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                        2'($urandom_range(0, 3)),
                        ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                        ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
            sl_mode = 1'($urandom_range(0, 1));
            run_round(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end
        sl_mode = 1'b0;

        check("leftover_done", 64'(exp_done_q.size()), 64'(0));
        check("leftover_writes", 64'(exp_wr_q.size()), 64'(0));

        // reset while the DELAY write is outstanding
        if (!aborted) begin
            sl_stall = 1'b1;
            @(negedge clk);
            req_delay[31:0] = 32'd7;
            req_ctrl[1:0]   = 2'b11;
            req_valid       = 4'b0001;
            budget = 0;
            while (!m_axi_awvalid && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            check("aw_w_valid_before_reset", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(2'b11));
            #2;
            rst = 1'b1;
            #1;
            check_reset_values("async_reset");
            req_valid = '0;
            exp_done_q.delete();
            exp_wr_q.delete();
            resp_q.delete();
            repeat (2) @(negedge clk);
            check_reset_values("held_reset");
            rst      = 1'b0;
            sl_stall = 1'b0;
            m_ptr    = 0;
            m_owner  = '0;
            m_ov     = 1'b0;
            repeat (2) @(negedge clk);

            // all four after reset: order restarts at requester 1
            for (int i = 0; i < N; i++) set_req(i, 32'(10 + i), 2'b11, 2'b00, 2'b00);
            run_round(4'b1111, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
